// File: rtl/xadac_axi_arbiter.sv
// Round-robin arbiter that shares one AXI master port between NumReq vector memory requesters.
// At most one single-beat transaction is in flight; its response is routed back to the owner.
module xadac_axi_arbiter #(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned DataWidth    = 128,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned UserWidth    = 1
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NumReq-1:0]                     req_valid,
    output logic [NumReq-1:0]                     req_ready,
    input  logic [NumReq-1:0]                     req_write,
    input  logic [NumReq-1:0][AddrWidth-1:0]      req_addr,
    input  logic [NumReq-1:0][DataWidth-1:0]      req_wdata,
    input  logic [NumReq-1:0][DataWidth/8-1:0]    req_wstrb,
    output logic [NumReq-1:0]                     resp_valid,
    input  logic [NumReq-1:0]                     resp_ready,
    output logic [DataWidth-1:0]                  resp_rdata,
    output logic                                  resp_err,
    output logic [IdWidth-1:0]                    mst_aw_id,
    output logic [AxiAddrWidth-1:0]               mst_aw_addr,
    output logic [7:0]                            mst_aw_len,
    output logic [2:0]                            mst_aw_size,
    output logic [1:0]                            mst_aw_burst,
    output logic                                  mst_aw_lock,
    output logic [3:0]                            mst_aw_cache,
    output logic [2:0]                            mst_aw_prot,
    output logic [3:0]                            mst_aw_qos,
    output logic [3:0]                            mst_aw_region,
    output logic [5:0]                            mst_aw_atop,
    output logic [UserWidth-1:0]                  mst_aw_user,
    output logic                                  mst_aw_valid,
    input  logic                                  mst_aw_ready,
    output logic [DataWidth-1:0]                  mst_w_data,
    output logic [DataWidth/8-1:0]                mst_w_strb,
    output logic                                  mst_w_last,
    output logic [UserWidth-1:0]                  mst_w_user,
    output logic                                  mst_w_valid,
    input  logic                                  mst_w_ready,
    input  logic [IdWidth-1:0]                    mst_b_id,
    input  logic [1:0]                            mst_b_resp,
    input  logic [UserWidth-1:0]                  mst_b_user,
    input  logic                                  mst_b_valid,
    output logic                                  mst_b_ready,
    output logic [IdWidth-1:0]                    mst_ar_id,
    output logic [AxiAddrWidth-1:0]               mst_ar_addr,
    output logic [7:0]                            mst_ar_len,
    output logic [2:0]                            mst_ar_size,
    output logic [1:0]                            mst_ar_burst,
    output logic                                  mst_ar_lock,
    output logic [3:0]                            mst_ar_cache,
    output logic [2:0]                            mst_ar_prot,
    output logic [3:0]                            mst_ar_qos,
    output logic [3:0]                            mst_ar_region,
    output logic [UserWidth-1:0]                  mst_ar_user,
    output logic                                  mst_ar_valid,
    input  logic                                  mst_ar_ready,
    input  logic [IdWidth-1:0]                    mst_r_id,
    input  logic [DataWidth-1:0]                  mst_r_data,
    input  logic [1:0]                            mst_r_resp,
    input  logic                                  mst_r_last,
    input  logic [UserWidth-1:0]                  mst_r_user,
    input  logic                                  mst_r_valid,
    output logic                                  mst_r_ready
);

    localparam int unsigned IdxWidth = $clog2(NumReq);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WB    = 3'd2,
        ST_RD_AR = 3'd3,
        ST_RD_R  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    state_e                  state_r, state_n;
    logic [IdxWidth-1:0]     ptr_r, grant_r, win_idx_s;
    logic                    win_found_s, accept_s, b_hs_s, r_hs_s, done_s;
    logic [AddrWidth-1:0]    addr_r;
    logic [DataWidth-1:0]    wdata_r, rdata_r;
    logic [DataWidth/8-1:0]  wstrb_r;
    logic                    aw_valid_r, w_valid_r, ar_valid_r, err_r;
    logic [NumReq-1:0]       resp_valid_r;
    logic                    unused_s;

    function automatic logic [NumReq-1:0] onehot(input logic [IdxWidth-1:0] idx);
        logic [NumReq-1:0] vec;
        vec      = {NumReq{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        if (idx == IdxWidth'(NumReq - 1)) begin
            return {IdxWidth{1'b0}};
        end else begin
            return idx + IdxWidth'(1'b1);
        end
    endfunction

    // Round-robin winner search; scanning in reverse lets the earliest candidate win
    always_comb begin
        int idx_v;
        idx_v       = 0;
        win_found_s = 1'b0;
        win_idx_s   = {IdxWidth{1'b0}};
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
            idx_v = int'(ptr_r) + k;
            if (idx_v >= int'(NumReq)) begin
                idx_v = idx_v - int'(NumReq);
            end else begin
                idx_v = idx_v;
            end
            if (req_valid[idx_v[IdxWidth-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = idx_v[IdxWidth-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign b_hs_s = (state_r == ST_WB) && mst_b_valid;
    assign r_hs_s = (state_r == ST_RD_R) && mst_r_valid;
    assign done_s = (state_r == ST_RESP) && resp_ready[grant_r];

    // Next-state logic and the combinational accept strobe
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        req_ready = {NumReq{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    accept_s  = 1'b1;
                    req_ready = onehot(win_idx_s);
                    state_n   = req_write[win_idx_s] ? ST_WR : ST_RD_AR;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WR: begin
                if ((!aw_valid_r || mst_aw_ready) && (!w_valid_r || mst_w_ready)) begin
                    state_n = ST_WB;
                end else begin
                    state_n = ST_WR;
                end
            end
            ST_WB:    state_n = b_hs_s ? ST_RESP : ST_WB;
            ST_RD_AR: state_n = mst_ar_ready ? ST_RD_R : ST_RD_AR;
            ST_RD_R:  state_n = r_hs_s ? ST_RESP : ST_RD_R;
            ST_RESP:  state_n = done_s ? ST_IDLE : ST_RESP;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State, pointer and latched request fields
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            ptr_r   <= {IdxWidth{1'b0}};
            grant_r <= {IdxWidth{1'b0}};
            addr_r  <= {AddrWidth{1'b0}};
            wdata_r <= {DataWidth{1'b0}};
            wstrb_r <= {(DataWidth/8){1'b0}};
        end else begin
            state_r <= state_n;
            if (accept_s) begin
                grant_r <= win_idx_s;
                addr_r  <= req_addr[win_idx_s];
                wdata_r <= req_wdata[win_idx_s];
                wstrb_r <= req_wstrb[win_idx_s];
            end
            if (done_s) begin
                ptr_r <= next_idx(grant_r);
            end
        end
    end

    // AXI valids and the response path; each valid falls on its own handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_valid_r   <= 1'b0;
            w_valid_r    <= 1'b0;
            ar_valid_r   <= 1'b0;
            resp_valid_r <= {NumReq{1'b0}};
            rdata_r      <= {DataWidth{1'b0}};
            err_r        <= 1'b0;
        end else begin
            if (accept_s) begin
                aw_valid_r <= req_write[win_idx_s];
                w_valid_r  <= req_write[win_idx_s];
                ar_valid_r <= !req_write[win_idx_s];
            end else begin
                if (aw_valid_r && mst_aw_ready) aw_valid_r <= 1'b0;
                if (w_valid_r && mst_w_ready)   w_valid_r  <= 1'b0;
                if (ar_valid_r && mst_ar_ready) ar_valid_r <= 1'b0;
            end
            if (b_hs_s) begin
                resp_valid_r <= onehot(grant_r);
                err_r        <= (mst_b_resp != 2'b00);
            end else if (r_hs_s) begin
                resp_valid_r <= onehot(grant_r);
                err_r        <= (mst_r_resp != 2'b00);
                rdata_r      <= mst_r_data;
            end else if (done_s) begin
                resp_valid_r <= {NumReq{1'b0}};
            end
        end
    end

    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = rdata_r;
    assign resp_err      = err_r;

    assign mst_aw_id     = IdWidth'(grant_r);
    assign mst_aw_addr   = AxiAddrWidth'(addr_r);
    assign mst_aw_len    = 8'd0;
    assign mst_aw_size   = 3'($clog2(DataWidth/8));
    assign mst_aw_burst  = 2'b01;
    assign mst_aw_lock   = 1'b0;
    assign mst_aw_cache  = 4'd0;
    assign mst_aw_prot   = 3'd0;
    assign mst_aw_qos    = 4'd0;
    assign mst_aw_region = 4'd0;
    assign mst_aw_atop   = 6'd0;
    assign mst_aw_user   = {UserWidth{1'b0}};
    assign mst_aw_valid  = aw_valid_r;

    assign mst_w_data    = wdata_r;
    assign mst_w_strb    = wstrb_r;
    assign mst_w_last    = 1'b1;
    assign mst_w_user    = {UserWidth{1'b0}};
    assign mst_w_valid   = w_valid_r;
    assign mst_b_ready   = (state_r == ST_WB);

    assign mst_ar_id     = IdWidth'(grant_r);
    assign mst_ar_addr   = AxiAddrWidth'(addr_r);
    assign mst_ar_len    = 8'd0;
    assign mst_ar_size   = 3'($clog2(DataWidth/8));
    assign mst_ar_burst  = 2'b01;
    assign mst_ar_lock   = 1'b0;
    assign mst_ar_cache  = 4'd0;
    assign mst_ar_prot   = 3'd0;
    assign mst_ar_qos    = 4'd0;
    assign mst_ar_region = 4'd0;
    assign mst_ar_user   = {UserWidth{1'b0}};
    assign mst_ar_valid  = ar_valid_r;
    assign mst_r_ready   = (state_r == ST_RD_R);

    // Response IDs, last and user are not needed with a single outstanding beat
    assign unused_s = ^{mst_b_id, mst_b_user, mst_r_id, mst_r_last, mst_r_user};

endmodule
